// File: rtl/trng_uart_tx.sv
// UART 8N1 byte transmitter for the TRNG host link: one-byte holding register, RTS gating
// at byte starts, and a frame marker pulse after every FRAME_BYTES-th byte.
module trng_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int STOP_BITS    = 1,
  parameter int FRAME_BYTES  = 256
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_dat,
  input  logic       i_write,
  input  logic       i_serial_rts_n,
  output logic       o_ready,
  output logic       o_serial_data,
  output logic       o_new_frame,
  output logic       o_busy,
  output logic       o_overflow
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int FW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shifter, shifter_nxt;
  logic [7:0]    hold, hold_nxt;
  logic          hold_valid, hold_valid_nxt;
  logic          overflow_nxt;
  logic [FW-1:0] frame_cnt, frame_cnt_nxt;
  logic          new_frame_nxt;
  logic          line_nxt;
  logic          rts_meta, rts_sync;
  logic          rts_ok, bit_end, stop_end, load;

  assign rts_ok   = ~rts_sync;
  assign bit_end  = (timer == TIMER_LAST);
  assign stop_end = (state == STOP) && bit_end && (idx == STOP_LAST);
  assign load     = hold_valid && rts_ok && ((state == IDLE) || stop_end);

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    idx_nxt     = idx;
    shifter_nxt = shifter;
    if (state != IDLE) timer_nxt = bit_end ? '0 : timer + 1'b1;
    case (state)
      START: if (bit_end) state_nxt = DATA;
      DATA: begin
        if (bit_end) begin
          if (idx == 3'd7) begin
            state_nxt = STOP;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (idx == STOP_LAST) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      default: ;
    endcase
    // a pending byte follows the last stop cycle directly, so no idle gap appears
    if (load) begin
      state_nxt   = START;
      timer_nxt   = '0;
      idx_nxt     = '0;
      shifter_nxt = hold;
    end
  end

  always_comb begin
    hold_nxt       = hold;
    hold_valid_nxt = hold_valid;
    overflow_nxt   = o_overflow;
    if (load) hold_valid_nxt = 1'b0;
    if (i_write) begin
      if (!hold_valid || load) begin
        hold_nxt       = i_dat;
        hold_valid_nxt = 1'b1;
      end else begin
        overflow_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    frame_cnt_nxt = frame_cnt;
    new_frame_nxt = 1'b0;
    if (stop_end) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt_nxt = '0;
        new_frame_nxt = 1'b1;
      end else begin
        frame_cnt_nxt = frame_cnt + 1'b1;
      end
    end
  end

  // line is registered from the next state so it lines up with the state register
  always_comb begin
    case (state_nxt)
      START:   line_nxt = 1'b0;
      DATA:    line_nxt = shifter_nxt[idx_nxt];
      default: line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      timer         <= '0;
      idx           <= '0;
      shifter       <= '0;
      hold          <= '0;
      hold_valid    <= 1'b0;
      frame_cnt     <= '0;
      rts_meta      <= 1'b1;
      rts_sync      <= 1'b1;
      o_ready       <= 1'b1;
      o_serial_data <= 1'b1;
      o_new_frame   <= 1'b0;
      o_busy        <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      idx           <= idx_nxt;
      shifter       <= shifter_nxt;
      hold          <= hold_nxt;
      hold_valid    <= hold_valid_nxt;
      frame_cnt     <= frame_cnt_nxt;
      rts_meta      <= i_serial_rts_n;
      rts_sync      <= rts_meta;
      o_ready       <= ~hold_valid_nxt;
      o_serial_data <= line_nxt;
      o_new_frame   <= new_frame_nxt;
      o_busy        <= (state_nxt != IDLE);
      o_overflow    <= overflow_nxt;
    end
  end

endmodule

// File: tb/tb_trng_uart_tx.sv
// Self-checking bench for trng_uart_tx: serial-line monitor with an expected-byte queue,
// a table of upstream-paced bytes, and directed RTS / overflow / reset sequences.
`timescale 1ns/1ps
module tb_trng_uart_tx;
  localparam int CPB      = 4;
  localparam int NSTOP    = 1;
  localparam int NFRAME   = 3;
  localparam int BYTE_CYC = (9 + NSTOP) * CPB;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_dat = 8'h00;
  logic       i_write = 1'b0;
  logic       i_serial_rts_n = 1'b1;
  logic       o_ready, o_serial_data, o_new_frame, o_busy, o_overflow;

  trng_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(NSTOP), .FRAME_BYTES(NFRAME)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_dat(i_dat), .i_write(i_write),
    .i_serial_rts_n(i_serial_rts_n), .o_ready(o_ready), .o_serial_data(o_serial_data),
    .o_new_frame(o_new_frame), .o_busy(o_busy), .o_overflow(o_overflow));

  always #5 i_clk = ~i_clk;

  typedef struct { logic [7:0] dat; logic nf; } exp_t;
  exp_t sb_q[$];
  exp_t vecs[5];
  int n_checks = 0;
  int n_fail   = 0;
  int busy_run = 0;
  int last_run = 0;
  int nf_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_new_frame) nf_pulses++;
    if (o_busy) busy_run++;
    else if (busy_run != 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
  end

  // receiver: every cycle of a frame is sampled, each bit must be flat for CPB cycles
  initial begin : monitor
    logic s [BYTE_CYC];
    logic [7:0] got;
    exp_t e;
    int glitches;
    bit aborted;
    forever begin
      @(negedge i_clk);
      while (!i_reset && o_serial_data == 1'b0) begin
        aborted = 1'b0;
        s[0] = o_serial_data;
        for (int k = 1; k < BYTE_CYC; k++) begin
          @(negedge i_clk);
          if (i_reset) begin
            aborted = 1'b1;
            break;
          end
          s[k] = o_serial_data;
        end
        if (aborted) break;
        glitches = 0;
        for (int k = 0; k < BYTE_CYC; k++) if (s[k] !== s[(k / CPB) * CPB]) glitches++;
        for (int b = 0; b < 8; b++) got[b] = s[(b + 1) * CPB];
        check("mon_bit_stable", glitches, 0);
        check("mon_stop_bit", s[9 * CPB], 1);
        @(negedge i_clk);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL mon_unexpected_byte: got 0x%0h, want no byte", got);
        end else begin
          e = sb_q.pop_front();
          check("mon_data", got, e.dat);
          check("mon_new_frame", o_new_frame, e.nf);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic apply_reset(input logic rts_n);
    i_reset = 1'b1;
    i_write = 1'b0;
    i_serial_rts_n = rts_n;
    tick(3);
    i_reset = 1'b0;
    sb_q.delete();
    tick(3);
  endtask

  task automatic do_write(input logic [7:0] dat, input bit accept, input logic nf);
    i_dat = dat;
    i_write = 1'b1;
    if (accept) sb_q.push_back('{dat, nf});
    tick(1);
    i_write = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!o_ready && n < 2000) begin
      tick(1);
      n++;
    end
    check({name, "_ready_wait"}, o_ready, 1);
  endtask

  task automatic upstream_write(input string name, input logic [7:0] dat, input logic nf);
    wait_ready(name);
    tick(2);
    do_write(dat, 1'b1, nf);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((o_busy || sb_q.size() != 0) && n < 3000) begin
      tick(1);
      n++;
    end
    check({name, "_drain"}, sb_q.size(), 0);
    tick(2);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, want test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int low;
    int p0;

    vecs[0] = '{8'h00, 1'b0};
    vecs[1] = '{8'hFF, 1'b0};
    vecs[2] = '{8'h5A, 1'b1};
    vecs[3] = '{8'h81, 1'b0};
    vecs[4] = '{8'h7E, 1'b0};

    // reset state and single byte timing
    apply_reset(1'b0);
    check("rst_line", o_serial_data, 1);
    check("rst_ready", o_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_new_frame", o_new_frame, 0);
    do_write(8'hA5, 1'b1, 1'b0);
    check("t1_load_cycle_line", o_serial_data, 1);
    tick(1);
    check("t1_start_line", o_serial_data, 0);
    check("t1_busy", o_busy, 1);
    wait_drain("t1");
    check("t1_busy_cycles", last_run, BYTE_CYC);

    // reset in the middle of 0xFF with another byte held
    apply_reset(1'b0);
    do_write(8'h11, 1'b1, 1'b0);
    wait_drain("t6_pre");
    do_write(8'hFF, 1'b1, 1'b0);
    tick(1);
    do_write(8'hEE, 1'b1, 1'b0);
    tick(12);
    check("t6_busy_before", o_busy, 1);
    check("t6_ready_before", o_ready, 0);
    i_reset = 1'b1;
    tick(1);
    check("t6_line", o_serial_data, 1);
    check("t6_busy", o_busy, 0);
    check("t6_ready", o_ready, 1);
    i_reset = 1'b0;
    sb_q.delete();
    tick(3);

    // table of upstream-paced bytes, frame counter starts from zero after the abort
    p0 = nf_pulses;
    for (int i = 0; i < 5; i++) upstream_write("t2", vecs[i].dat, vecs[i].nf);
    wait_drain("t2");
    check("t2_busy_cycles", last_run, 5 * BYTE_CYC);
    check("t2_frame_pulses", nf_pulses - p0, 1);
    check("t2_overflow", o_overflow, 0);

    // RTS held off, then released
    apply_reset(1'b1);
    do_write(8'h3C, 1'b1, 1'b0);
    low = 0;
    repeat (20) begin
      tick(1);
      if (o_serial_data == 1'b0) low++;
    end
    check("t3_line_held", low, 0);
    check("t3_ready", o_ready, 0);
    check("t3_busy", o_busy, 0);
    i_serial_rts_n = 1'b0;
    n = 0;
    while (o_serial_data && n < 20) begin
      tick(1);
      n++;
    end
    check("t3_start_latency", n, 3);
    wait_drain("t3");

    // RTS dropped mid-byte with a second byte waiting
    apply_reset(1'b0);
    do_write(8'h96, 1'b1, 1'b0);
    upstream_write("t4", 8'h69, 1'b0);
    i_serial_rts_n = 1'b1;
    n = 0;
    while (o_busy && n < 100) begin
      tick(1);
      n++;
    end
    check("t4_byte1_done", o_busy, 0);
    low = 0;
    repeat (30) begin
      tick(1);
      if (o_serial_data == 1'b0) low++;
    end
    check("t4_line_held", low, 0);
    check("t4_ready", o_ready, 0);
    i_serial_rts_n = 1'b0;
    wait_drain("t4");

    // write during load is kept; writes into a full holding register are dropped
    apply_reset(1'b0);
    do_write(8'h12, 1'b1, 1'b0);
    do_write(8'h34, 1'b1, 1'b0);
    check("t5_no_overflow_on_load", o_overflow, 0);
    check("t5_ready_full", o_ready, 0);
    do_write(8'h56, 1'b0, 1'b0);
    check("t5_overflow", o_overflow, 1);
    tick(2);
    do_write(8'h78, 1'b0, 1'b0);
    wait_drain("t5");
    check("t5_overflow_sticky", o_overflow, 1);
    check("t5_ready_after", o_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
